// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: shares one memory port between instruction fetch
// and load/store, one transaction outstanding, fixed-latency read return.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_LIM = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);
    localparam int LAT_W = $clog2(MEM_LAT + 1);
    localparam int STV_W = $clog2(STARVE_LIM + 1);
    localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(MEM_LAT);
    localparam logic [STV_W-1:0] STV_MAX = STV_W'(STARVE_LIM);

    typedef enum logic {IDLE, WAIT} state_t;
    typedef enum logic {OWN_IF, OWN_D} owner_t;

    state_t            state, state_nxt;
    owner_t            owner, owner_nxt;
    logic [LAT_W-1:0]  lat_cnt, lat_nxt;
    logic [STV_W-1:0]  starve_cnt, starve_nxt;
    logic              resp, issue_slot, if_win, d_win;

    // Everything is gated by rst so outputs are quiet while reset is held.
    assign resp       = rst && (state == WAIT) && (lat_cnt == LAT_MAX);
    assign issue_slot = rst && ((state == IDLE) || resp);
    assign if_win     = issue_slot && if_req && (!d_req || (starve_cnt == STV_MAX));
    assign d_win      = issue_slot && d_req && !if_win;

    assign if_rdata = mem_rdata;
    assign d_rdata  = mem_rdata;

    always_comb begin
        state_nxt  = state;
        owner_nxt  = owner;
        lat_nxt    = lat_cnt;
        starve_nxt = starve_cnt;
        if_gnt     = 1'b0;
        d_gnt      = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_be     = '0;
        busy       = rst && (state == WAIT);
        if_rvalid  = resp && (owner == OWN_IF);
        d_rvalid   = resp && (owner == OWN_D);

        if ((state == WAIT) && (lat_cnt != LAT_MAX))
            lat_nxt = lat_cnt + LAT_W'(1);
        if (resp) begin
            state_nxt = IDLE;
            lat_nxt   = '0;
        end

        if (if_win) begin
            if_gnt     = 1'b1;
            mem_en     = 1'b1;
            mem_addr   = if_addr;
            mem_be     = '1;
            owner_nxt  = OWN_IF;
            starve_nxt = '0;
        end else if (d_win) begin
            d_gnt     = 1'b1;
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_be    = d_be;
            owner_nxt = OWN_D;
            // Count only data grants that make a waiting fetch wait longer.
            if (!if_req)
                starve_nxt = '0;
            else if (starve_cnt != STV_MAX)
                starve_nxt = starve_cnt + STV_W'(1);
        end

        if (if_win || d_win) begin
            state_nxt = WAIT;
            lat_nxt   = LAT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= OWN_IF;
            lat_cnt    <= '0;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            lat_cnt    <= lat_nxt;
            starve_cnt <= starve_nxt;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic,
// every cycle compared against a transaction-level reference model.
module tb_mem_port_arbiter;
    localparam int AW = 32, DW = 32, BW = 4, LAT = 2, SL = 4;

    logic          clk = 1'b0, rst = 1'b0;
    logic          if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [AW-1:0] if_addr = '0, d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [BW-1:0] d_be = '0;
    logic          if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy;
    logic [DW-1:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;
    logic [BW-1:0] mem_be;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_LIM(SL)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata), .busy(busy)
    );

    function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
        return (a == 32'h10) ? 32'h00500093 : ({a[15:0], ~a[15:0]} ^ 32'h13579BDF);
    endfunction

    // Fixed-latency memory: read data appears LAT cycles after the mem_en cycle.
    logic [LAT-1:0] p_v;
    logic [AW-1:0]  p_a [LAT];
    logic [DW-1:0]  junk;
    always @(posedge clk) begin
        p_v[0] <= mem_en & ~mem_we;
        p_a[0] <= mem_addr;
        for (int i = 1; i < LAT; i++) begin
            p_v[i] <= p_v[i-1];
            p_a[i] <= p_a[i-1];
        end
        junk <= $urandom;
    end
    assign mem_rdata = p_v[LAT-1] ? rom(p_a[LAT-1]) : junk;

    int checks = 0, failures = 0;
    int cyc = 0, out_due = -1, starve = 0, if_left = 0, d_left = 0, rec_i = 0;
    bit out_own_d, out_we, e_ig, e_dg;
    logic [AW-1:0] out_addr;
    bit r_ig[32], r_dg[32], r_ir[32], r_dr[32], r_busy[32], r_en[32], r_we[32];
    logic [31:0] r_addr[32], r_wd[32], r_ird[32];
    logic [3:0]  r_be[32];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge; returns just after the following rising edge.
    task automatic eval();
        bit resp, can, x_en, x_we, x_busy, x_ir, x_dr;
        logic [AW-1:0] x_addr;
        logic [DW-1:0] x_wd;
        logic [BW-1:0] x_be;
        #1;
        {e_ig, e_dg, resp, x_en, x_we, x_busy, x_ir, x_dr} = '0;
        x_addr = '0; x_wd = '0; x_be = '0;
        if (!rst) begin
            out_due = -1;
            starve  = 0;
        end else begin
            resp = (out_due == cyc);
            can  = (out_due < 0) || resp;
            e_ig = can && if_req && (!d_req || starve == SL);
            e_dg = can && d_req && !e_ig;
            x_busy = (out_due >= 0);
            x_ir = resp && !out_own_d;
            x_dr = resp && out_own_d;
            if (e_ig) begin
                x_en = 1; x_addr = if_addr; x_be = '1;
            end else if (e_dg) begin
                x_en = 1; x_we = d_we; x_addr = d_addr; x_wd = d_wdata; x_be = d_be;
            end
        end
        chk("if_gnt", 64'(if_gnt), 64'(e_ig));
        chk("d_gnt", 64'(d_gnt), 64'(e_dg));
        chk("mem_en", 64'(mem_en), 64'(x_en));
        chk("mem_we", 64'(mem_we), 64'(x_we));
        chk("mem_addr", 64'(mem_addr), 64'(x_addr));
        chk("mem_wdata", 64'(mem_wdata), 64'(x_wd));
        chk("mem_be", 64'(mem_be), 64'(x_be));
        chk("busy", 64'(busy), 64'(x_busy));
        chk("if_rvalid", 64'(if_rvalid), 64'(x_ir));
        chk("d_rvalid", 64'(d_rvalid), 64'(x_dr));
        chk("if_rdata_pass", 64'(if_rdata), 64'(mem_rdata));
        chk("d_rdata_pass", 64'(d_rdata), 64'(mem_rdata));
        if (resp && !out_we)
            chk("read_data", 64'(out_own_d ? d_rdata : if_rdata), 64'(rom(out_addr)));
        if (rst) begin
            if (resp) out_due = -1;
            if (e_ig || e_dg) begin
                out_due   = cyc + LAT;
                out_own_d = e_dg;
                out_we    = e_dg && d_we;
                out_addr  = e_dg ? d_addr : if_addr;
                starve    = (e_dg && if_req) ? ((starve < SL) ? starve + 1 : SL) : 0;
            end
        end
        if (rec_i < 32) begin
            r_ig[rec_i] = if_gnt;  r_dg[rec_i] = d_gnt;  r_ir[rec_i] = if_rvalid;
            r_dr[rec_i] = d_rvalid; r_busy[rec_i] = busy; r_en[rec_i] = mem_en;
            r_we[rec_i] = mem_we;  r_addr[rec_i] = mem_addr; r_wd[rec_i] = mem_wdata;
            r_be[rec_i] = mem_be;  r_ird[rec_i] = if_rdata;
        end
        rec_i++;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // Requesters hold until granted; *_left counts remaining back-to-back requests (-1 = endless).
    task automatic apply_drops();
        if (e_ig) begin
            if (if_left > 0) if_left--;
            if (if_left == 0) if_req = 0; else if_addr += 4;
        end
        if (e_dg) begin
            if (d_left > 0) d_left--;
            if (d_left == 0) d_req = 0; else d_addr += 4;
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            apply_drops();
            @(negedge clk);
            eval();
        end
    endtask

    task automatic do_reset();
        rst = 0; if_req = 0; d_req = 0; d_we = 0; if_left = 0; d_left = 0;
        run(2);
        rst = 1;
        rec_i = 0;
    endtask

    initial begin
        do_reset();
        chk("reset_busy", 64'(r_busy[0]), 64'(0));

        // Reset one cycle after a load grant discards the response.
        rec_i = 0;
        d_req = 1; d_we = 0; d_addr = 32'h300; d_left = 1;
        run(1);
        rst = 0;
        run(2);
        rst = 1; if_req = 1; if_addr = 32'h0; if_left = 1;
        run(3);
        chk("rstmid_dgnt0", 64'(r_dg[0]), 64'(1));
        for (int i = 1; i < 4; i++) begin
            chk("rstmid_no_drvalid", 64'(r_dr[i]), 64'(0));
            chk("rstmid_busy0", 64'(r_busy[i] & (i < 3)), 64'(0));
        end
        chk("rstmid_memen0", 64'(r_en[1] | r_en[2]), 64'(0));
        chk("rstmid_ifgnt_first", 64'(r_ig[3]), 64'(1));

        // Single fetch issued in cycle 5.
        do_reset();
        run(5);
        if_req = 1; if_addr = 32'h10; if_left = 1;
        run(4);
        chk("fetch_gnt5", 64'(r_ig[5]), 64'(1));
        chk("fetch_en5", 64'(r_en[5]), 64'(1));
        chk("fetch_addr5", 64'(r_addr[5]), 64'(32'h10));
        chk("fetch_rvalid7", 64'(r_ir[7]), 64'(1));
        chk("fetch_rdata7", 64'(r_ird[7]), 64'(32'h00500093));

        // Contention: data first, then fetch.
        do_reset();
        if_req = 1; if_addr = 32'h40; if_left = 1;
        d_req = 1; d_we = 0; d_addr = 32'h100; d_left = 1;
        run(6);
        chk("cont_dgnt0", 64'(r_dg[0]), 64'(1));
        chk("cont_ifgnt0", 64'(r_ig[0]), 64'(0));
        chk("cont_drvalid2", 64'(r_dr[2]), 64'(1));
        chk("cont_ifgnt2", 64'(r_ig[2]), 64'(1));
        chk("cont_ifrvalid4", 64'(r_ir[4]), 64'(1));

        // Starvation guard with both requesters held.
        do_reset();
        if_req = 1; if_addr = 32'h80; if_left = -1;
        d_req = 1; d_we = 0; d_addr = 32'h400; d_left = -1;
        run(11);
        for (int i = 0; i < 8; i += 2) chk("starve_dgnt", 64'(r_dg[i]), 64'(1));
        chk("starve_ifgnt8", 64'(r_ig[8]), 64'(1));
        chk("starve_dgnt8", 64'(r_dg[8]), 64'(0));
        chk("starve_dgnt10", 64'(r_dg[10]), 64'(1));

        // Store with partial byte enables.
        do_reset();
        d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF; d_be = 4'b0011; d_left = 1;
        run(4);
        chk("store_gnt", 64'(r_dg[0]), 64'(1));
        chk("store_we", 64'(r_we[0]), 64'(1));
        chk("store_be", 64'(r_be[0]), 64'(4'b0011));
        chk("store_addr", 64'(r_addr[0]), 64'(32'h200));
        chk("store_wdata", 64'(r_wd[0]), 64'(32'hDEADBEEF));
        chk("store_ack2", 64'(r_dr[2]), 64'(1));
        for (int i = 0; i < 4; i++) chk("store_no_ifrvalid", 64'(r_ir[i]), 64'(0));
        d_we = 0;

        // Back-to-back fetches.
        do_reset();
        if_req = 1; if_addr = 32'h0; if_left = 3;
        run(8);
        for (int i = 0; i < 3; i++) begin
            chk("b2b_gnt", 64'(r_ig[2*i]), 64'(1));
            chk("b2b_addr", 64'(r_addr[2*i]), 64'(4*i));
        end
        for (int i = 1; i <= 6; i++) chk("b2b_busy", 64'(r_busy[i]), 64'(1));
        chk("b2b_idle7", 64'(r_busy[7]), 64'(0));

        // Randomized traffic, occasional withdrawal and reset.
        do_reset();
        repeat (800) begin
            apply_drops();
            if (!rst) begin
                if ($urandom_range(1, 0) == 1) rst = 1;
            end else if ($urandom_range(149, 0) == 0) begin
                rst = 0; if_req = 0; d_req = 0;
            end else begin
                if (!if_req && $urandom_range(2, 0) == 0) begin
                    if_req = 1; if_left = 1; if_addr = $urandom & 32'hFFFC;
                end else if (if_req && $urandom_range(39, 0) == 0) begin
                    if_req = 0;
                end
                if (!d_req && $urandom_range(2, 0) == 0) begin
                    d_req = 1; d_left = 1; d_we = 1'($urandom);
                    d_addr = $urandom & 32'hFFFC; d_wdata = $urandom; d_be = 4'($urandom);
                end else if (d_req && $urandom_range(39, 0) == 0) begin
                    d_req = 0;
                end
            end
            @(negedge clk);
            eval();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Single-ported unified memory arbiter for the pipelined RISC-V core. Shares one memory port between the instruction-fetch requester (IF stage) and the load/store requester (MEM stage). Keeps at most one transaction outstanding, returns read data after a fixed memory latency, and gives data accesses priority with a bounded fetch-starvation guard. The pipeline stalls whenever its request is pending and not granted.

## Interface
- ADDR_W, 32, address width for both requesters and the memory.
- DATA_W, 32, data width; must be a multiple of 8.
- MEM_LAT, 2, cycles from the `mem_en` cycle to valid `mem_rdata`; must be ≥1.
- STARVE_LIM, 4, maximum consecutive data grants while a fetch waits; must be ≥1.

- clk  in  1  clock; single clock domain, all state on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held until `if_gnt`.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  fetch accepted this cycle.
- if_rvalid  out  1  fetch data valid this cycle.
- if_rdata  out  DATA_W  fetch read data.
- d_req  in  1  data request; held until `d_gnt`.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_be  in  DATA_W/8  store byte enables.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  load data valid, or store acknowledge.
- d_rdata  out  DATA_W  load read data.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_be  out  DATA_W/8  memory byte enables.
- mem_rdata  in  DATA_W  memory read data; valid MEM_LAT cycles after `mem_en`.
- busy  out  1  a transaction is outstanding.

## Operation
- **FSM states:** IDLE and WAIT.
- **Registered state:** `owner` (IF or D), `lat_cnt` of width clog2(MEM_LAT+1), and `starve_cnt` of width clog2(STARVE_LIM+1).
- **Issue is combinational** in IDLE, and in the WAIT cycle where `lat_cnt == MEM_LAT` (the response cycle):
  - If any request is present, select a winner and pulse its `gnt`.
  - Drive `mem_en = 1`.
  - Mux the winner's address, data and enables onto `mem_*`.
  - For a fetch: `mem_we = 0` and `mem_be` = all ones.
- **Outputs when nothing is issued:** `mem_en`, `mem_we`, `mem_addr`, `mem_wdata` and `mem_be` are all 0.
- **Winner selection:**
  - Fetch wins if `if_req & (!d_req | starve_cnt == STARVE_LIM)`.
  - Otherwise data wins if `d_req`.
- **starve_cnt update:**
  - Increments on a data grant while `if_req = 1`.
  - Clears on a fetch grant, and on any data grant while `if_req = 0`.
  - Saturates at STARVE_LIM.
- **On issue:** `owner` ← winner, `lat_cnt` ← 1, state ← WAIT.
- **In WAIT:** `lat_cnt` increments each cycle until it reaches MEM_LAT.
- **Response cycle** (`lat_cnt == MEM_LAT`):
  - Pulse `owner`'s `rvalid` for one cycle; stores also pulse `d_rvalid` as the acknowledge.
  - If a new issue happens in the same cycle, stay in WAIT with `lat_cnt` ← 1; otherwise go to IDLE.
- `if_rdata` and `d_rdata` both equal `mem_rdata` at all times; only `rvalid` qualifies them.
- `busy` = 1 in WAIT.
- **Reset (asserted at any time, including mid-transaction):**
  - State ← IDLE; `lat_cnt`, `starve_cnt` and `owner` ← 0.
  - The outstanding response is discarded and no `rvalid` is produced for it.
  - Every output is 0 while reset is held, except that `*_rdata` follow `mem_rdata`.

## Timing
- Grant in cycle t → `rvalid` in cycle t+MEM_LAT.
- Next grant is possible in cycle t+MEM_LAT, so peak throughput is one access per MEM_LAT cycles.
- Requests arriving in WAIT before the response cycle are not granted; `gnt` stays 0.
- **Simultaneous `if_req` and `d_req` in an issue cycle:** data wins unless `starve_cnt == STARVE_LIM`.
- At most one `gnt` and at most one `rvalid` are high in any cycle.
- A request that is withdrawn before its grant is never issued.

## Test plan
All scenarios use MEM_LAT=2 and STARVE_LIM=4.
- **Reset mid-read:**
  - Stimulus: assert reset one cycle after `d_gnt`.
  - Response: no `d_rvalid`; `busy = 0`; `mem_en = 0`; after release, a fresh `if_req` to 0x0 is granted in the first cycle.
- **Single fetch:**
  - Stimulus: `if_req` with `if_addr = 0x10` in cycle 5; memory returns 0x00500093 two cycles after `mem_en`.
  - Response: `if_gnt`, `mem_en = 1` and `mem_addr = 0x10` in cycle 5; `if_rvalid = 1` with `if_rdata = 0x00500093` in cycle 7.
- **Contention:**
  - Stimulus: `if_req` and `d_req` (load from 0x100) both asserted in cycle 0.
  - Response: `d_gnt` in cycle 0; `d_rvalid` and `if_gnt` in cycle 2; `if_rvalid` in cycle 4.
- **Starvation guard:**
  - Stimulus: `d_req` and `if_req` held high continuously.
  - Response: `d_gnt` in cycles 0, 2, 4 and 6; `if_gnt` in cycle 8; `d_gnt` again in cycle 10.
- **Store:**
  - Stimulus: `d_we = 1`, `d_addr = 0x200`, `d_wdata = 0xDEADBEEF`, `d_be = 4'b0011`.
  - Response: in the grant cycle, `mem_we = 1` and `mem_be = 0011` with matching address and data; `d_rvalid` two cycles later; `if_rvalid` stays 0 throughout.
- **Back-to-back fetches:**
  - Stimulus: `if_req` held with addresses 0x0, 0x4, 0x8.
  - Response: grants in cycles 0, 2 and 4; `busy` stays 1 from cycle 1 through cycle 6.
